// File: rtl/fp_mul_arbiter_pkg.sv
// Shared definitions for the round-robin FP32 multiplier arbiter:
// FSM state encoding, operand width, and flag vector layout.
package fp_mul_arbiter_pkg;

  localparam int FP_W     = 32;
  localparam int FLAG_W   = 3;
  localparam int FLAG_EXC = 2;
  localparam int FLAG_OVF = 1;
  localparam int FLAG_UNF = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_EXEC  = 2'd1,
    ST_EXEC2 = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

endpackage

// File: rtl/Multiplication.sv
// Combinational IEEE-754 single multiplier with round-to-nearest-even;
// overflow saturates to signed infinity, underflow flushes to signed zero.
module Multiplication (
  input  logic [31:0] a_operand,
  input  logic [31:0] b_operand,
  output logic        Exception,
  output logic        Overflow,
  output logic        Underflow,
  output logic [31:0] result
);

  logic              sign;
  logic [7:0]        ea, eb;
  logic [23:0]       ma, mb;
  logic [47:0]       prod;
  logic [46:0]       prod_n;
  logic              norm, round_up;
  logic [23:0]       mant_r;
  logic signed [9:0] exp_sum;

  always_comb begin
    ea       = a_operand[30:23];
    eb       = b_operand[30:23];
    ma       = {|ea, a_operand[22:0]};
    mb       = {|eb, b_operand[22:0]};
    sign     = a_operand[31] ^ b_operand[31];
    prod     = ma * mb;
    norm     = prod[47];
    prod_n   = norm ? prod[46:0] : {prod[45:0], 1'b0};
    // guard bit, then ties broken towards an even mantissa
    round_up = prod_n[23] & ((|prod_n[22:0]) | prod_n[24]);
    mant_r   = {1'b0, prod_n[46:24]} + {23'b0, round_up};
    exp_sum  = $signed({2'b0, ea}) + $signed({2'b0, eb}) - 10'sd127
             + $signed({9'b0, norm}) + $signed({9'b0, mant_r[23]});

    Exception = (&ea) | (&eb);
    Overflow  = 1'b0;
    Underflow = 1'b0;
    result    = 32'h0;
    if (Exception) begin
      result = 32'h0;
    end else if (a_operand[30:0] == 31'h0 || b_operand[30:0] == 31'h0) begin
      result = {sign, 31'h0};
    end else if (exp_sum > 10'sd254) begin
      Overflow = 1'b1;
      result   = {sign, 8'hFF, 23'h0};
    end else if (exp_sum < 10'sd1) begin
      Underflow = 1'b1;
      result    = {sign, 31'h0};
    end else begin
      result = {sign, exp_sum[7:0], mant_r[22:0]};
    end
  end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin grant: searches upward from ptr with wrap-around and returns
// the first asserted request as a one-hot grant plus its encoded index.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    idx
);

  localparam int SW = ID_W + 1;

  logic [SW-1:0]   sum;
  logic [ID_W-1:0] cand;
  logic            found;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    sum   = '0;
    cand  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sum = {1'b0, ptr} + SW'(i);
      if (sum >= SW'(NUM_REQ)) sum = sum - SW'(NUM_REQ);
      cand = sum[ID_W-1:0];
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        idx         = cand;
      end
    end
  end

endmodule

// File: rtl/fp_mul_arbiter.sv
// NUM_REQ requesters share one FP32 multiplier, one operation in flight.
// Define FP_MUL_ARB_PIPE_EN to add a register stage after the multiplier.
module fp_mul_arbiter
  import fp_mul_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                    CLK,
  input  logic                    RESET_N,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [FP_W*NUM_REQ-1:0] req_a,
  input  logic [FP_W*NUM_REQ-1:0] req_b,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [ID_W-1:0]         rsp_id,
  output logic [FP_W-1:0]         rsp_result,
  output logic [FLAG_W-1:0]       rsp_flags,
  output logic                    busy
);

  state_t          state_reg;
  logic [ID_W-1:0] ptr_reg, op_id_reg, win_idx;
  logic [FP_W-1:0] op_a_reg, op_b_reg, mul_result;
  logic [FLAG_W-1:0] mul_flags;
  logic [NUM_REQ-1:0] grant;
  logic [FP_W-1:0] a_slice [NUM_REQ];
  logic [FP_W-1:0] b_slice [NUM_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign a_slice[gi] = req_a[FP_W*gi +: FP_W];
      assign b_slice[gi] = req_b[FP_W*gi +: FP_W];
    end
  endgenerate

  rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_rr (
    .req   (req_valid),
    .ptr   (ptr_reg),
    .grant (grant),
    .idx   (win_idx)
  );

  Multiplication u_mul (
    .a_operand (op_a_reg),
    .b_operand (op_b_reg),
    .Exception (mul_flags[FLAG_EXC]),
    .Overflow  (mul_flags[FLAG_OVF]),
    .Underflow (mul_flags[FLAG_UNF]),
    .result    (mul_result)
  );

  // Grant is only offered while idle, so a handshake always starts a fresh op.
  assign req_ready = (state_reg == ST_IDLE) ? grant : '0;
  assign busy      = (state_reg != ST_IDLE);

`ifdef FP_MUL_ARB_PIPE_EN
  logic [FP_W-1:0]   pipe_result_reg;
  logic [FLAG_W-1:0] pipe_flags_reg;
`endif

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_reg  <= ST_IDLE;
      ptr_reg    <= '0;
      op_a_reg   <= '0;
      op_b_reg   <= '0;
      op_id_reg  <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_result <= '0;
      rsp_flags  <= '0;
`ifdef FP_MUL_ARB_PIPE_EN
      pipe_result_reg <= '0;
      pipe_flags_reg  <= '0;
`endif
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (|grant) begin
            op_a_reg  <= a_slice[win_idx];
            op_b_reg  <= b_slice[win_idx];
            op_id_reg <= win_idx;
            ptr_reg   <= (win_idx == ID_W'(NUM_REQ-1)) ? '0 : win_idx + ID_W'(1);
            state_reg <= ST_EXEC;
          end
        end
        ST_EXEC: begin
`ifdef FP_MUL_ARB_PIPE_EN
          pipe_result_reg <= mul_result;
          pipe_flags_reg  <= mul_flags;
          state_reg       <= ST_EXEC2;
`else
          rsp_result <= mul_result;
          rsp_flags  <= mul_flags;
          rsp_id     <= op_id_reg;
          rsp_valid  <= 1'b1;
          state_reg  <= ST_RESP;
`endif
        end
        ST_EXEC2: begin
`ifdef FP_MUL_ARB_PIPE_EN
          rsp_result <= pipe_result_reg;
          rsp_flags  <= pipe_flags_reg;
          rsp_id     <= op_id_reg;
          rsp_valid  <= 1'b1;
          state_reg  <= ST_RESP;
`else
          state_reg  <= ST_IDLE;
`endif
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state_reg <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_mul_arbiter.sv
// Directed bench for fp_mul_arbiter: vector table plus round-robin,
// back-pressure and mid-operation reset sequences.
module tb_fp_mul_arbiter;

`ifdef FP_MUL_ARB_PIPE_EN
  localparam int EXP_LAT = 2;
`else
  localparam int EXP_LAT = 1;
`endif
  localparam int SPACING = EXP_LAT + 2;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   req_valid;
  logic [127:0] req_a, req_b;
  logic [3:0]   req_ready;
  logic         rsp_valid, rsp_ready, busy;
  logic [1:0]   rsp_id;
  logic [31:0]  rsp_result;
  logic [2:0]   rsp_flags;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  fp_mul_arbiter #(.NUM_REQ(4), .ID_W(2)) dut (
    .CLK        (clk),
    .RESET_N    (rst_n),
    .req_valid  (req_valid),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_flags  (rsp_flags),
    .busy       (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [3:0]  valid;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  grant;
    logic [1:0]  id;
    logic [31:0] result;
    logic [2:0]  flags;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_grant(output logic [3:0] g);
    g = '0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (req_ready != 4'b0) begin
        g = req_ready;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic wait_rsp(output int lat);
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (rsp_valid) break;
    end
  endtask

  task automatic wait_rsp_neg();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rsp_valid) break;
    end
  endtask

  logic [3:0] g;
  int         lat, last;
  int         rr_ids [5];

  initial begin
    //          valid    a             b             grant    id     result        flags
    vecs[0] = '{4'b0001, 32'h40A00000, 32'h40A00000, 4'b0001, 2'd0, 32'h41C80000, 3'b000};
    vecs[1] = '{4'b0100, 32'h7F000000, 32'h7F000000, 4'b0100, 2'd2, 32'h7F800000, 3'b010};
    vecs[2] = '{4'b0011, 32'h40000000, 32'h40400000, 4'b0001, 2'd0, 32'h40C00000, 3'b000};
    vecs[3] = '{4'b1001, 32'h40000000, 32'h40400000, 4'b1000, 2'd3, 32'h40C00000, 3'b000};
    vecs[4] = '{4'b1111, 32'h3F800000, 32'h3F800000, 4'b0001, 2'd0, 32'h3F800000, 3'b000};
    vecs[5] = '{4'b1010, 32'hC0000000, 32'h40400000, 4'b0010, 2'd1, 32'hC0C00000, 3'b000};
    vecs[6] = '{4'b0010, 32'h00000000, 32'h40A00000, 4'b0010, 2'd1, 32'h00000000, 3'b000};
    vecs[7] = '{4'b0100, 32'h00800000, 32'h00800000, 4'b0100, 2'd2, 32'h00000000, 3'b001};
    vecs[8] = '{4'b1000, 32'h7F800000, 32'h40000000, 4'b1000, 2'd3, 32'h00000000, 3'b100};
    rr_ids = '{0, 1, 2, 3, 0};

    rst_n     = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rsp_id", 32'(rsp_id), 32'd0);
    chk("rst_rsp_result", rsp_result, 32'd0);
    chk("rst_rsp_flags", 32'(rsp_flags), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_req_ready", 32'(req_ready), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);

    // table-driven single transactions
    for (int v = 0; v < 9; v++) begin
      @(negedge clk);
      req_valid = vecs[v].valid;
      req_a     = {4{vecs[v].a}};
      req_b     = {4{vecs[v].b}};
      wait_grant(g);
      chk($sformatf("v%0d_grant", v), 32'(g), 32'(vecs[v].grant));
      @(posedge clk);
      #1 req_valid = '0;
      wait_rsp(lat);
      chk($sformatf("v%0d_latency", v), 32'(lat), 32'(EXP_LAT));
      chk($sformatf("v%0d_id", v), 32'(rsp_id), 32'(vecs[v].id));
      chk($sformatf("v%0d_result", v), rsp_result, vecs[v].result);
      chk($sformatf("v%0d_flags", v), 32'(rsp_flags), 32'(vecs[v].flags));
      chk($sformatf("v%0d_busy", v), 32'(busy), 32'd1);
      chk($sformatf("v%0d_ready_resp", v), 32'(req_ready), 32'd0);
      $display("vec %0d: grant=%b id=%0d result=%h flags=%b lat=%0d",
               v, g, rsp_id, rsp_result, rsp_flags, lat);
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("v%0d_rsp_clear", v), 32'(rsp_valid), 32'd0);
      chk($sformatf("v%0d_idle", v), 32'(busy), 32'd0);
    end

    // all four requesting continuously: strict rotation at minimum spacing
    @(negedge clk);
    req_valid = 4'b1111;
    req_a     = {4{32'h40000000}};
    req_b     = {4{32'h40400000}};
    last      = 0;
    for (int k = 0; k < 5; k++) begin
      wait_grant(g);
      chk($sformatf("rr%0d_grant", k), 32'(g), 32'(4'b0001 << rr_ids[k]));
      if (k > 0) chk($sformatf("rr%0d_spacing", k), 32'(cyc - last), 32'(SPACING));
      last = cyc;
      wait_rsp_neg();
      chk($sformatf("rr%0d_id", k), 32'(rsp_id), 32'(rr_ids[k]));
      chk($sformatf("rr%0d_result", k), rsp_result, 32'h40C00000);
      $display("rr %0d: grant=%b id=%0d result=%h", k, g, rsp_id, rsp_result);
    end
    req_valid = '0;

    // back-pressure: response held, no grants while waiting
    @(negedge clk);
    rsp_ready = 1'b0;
    req_valid = 4'b0100;
    req_a     = {4{32'h40A00000}};
    req_b     = {4{32'h40A00000}};
    wait_grant(g);
    chk("bp_grant", 32'(g), 32'(4'b0100));
    @(posedge clk);
    #1 req_valid = 4'b1111;
    wait_rsp_neg();
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      chk($sformatf("bp%0d_valid", i), 32'(rsp_valid), 32'd1);
      chk($sformatf("bp%0d_id", i), 32'(rsp_id), 32'd2);
      chk($sformatf("bp%0d_result", i), rsp_result, 32'h41C80000);
      chk($sformatf("bp%0d_ready", i), 32'(req_ready), 32'd0);
      chk($sformatf("bp%0d_busy", i), 32'(busy), 32'd1);
    end
    $display("bp: held id=%0d result=%h for 5 cycles", rsp_id, rsp_result);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_accept_valid", 32'(rsp_valid), 32'd0);
    chk("bp_next_grant", 32'(req_ready), 32'(4'b1000));
    req_valid = '0;

    // idle without requests: nothing moves
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("quiet%0d_valid", i), 32'(rsp_valid), 32'd0);
      chk($sformatf("quiet%0d_ready", i), 32'(req_ready), 32'd0);
      chk($sformatf("quiet%0d_result", i), rsp_result, 32'h41C80000);
    end

    // reset during EXEC: operation dropped, pointer back to 0
    req_valid = 4'b0010;
    req_a     = {4{32'h40000000}};
    req_b     = {4{32'h40400000}};
    wait_grant(g);
    chk("rstop_grant", 32'(g), 32'(4'b0010));
    @(posedge clk);
    #1 req_valid = '0;
    rst_n = 1'b0;
    #1;
    chk("rstop_busy", 32'(busy), 32'd0);
    chk("rstop_valid", 32'(rsp_valid), 32'd0);
    chk("rstop_result", rsp_result, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("rstop%0d_no_rsp", i), 32'(rsp_valid), 32'd0);
    end
    req_valid = 4'b1111;
    wait_grant(g);
    chk("rstop_first_grant", 32'(g), 32'(4'b0001));
    req_valid = '0;
    $display("rst: in-flight op dropped, first grant=%b", g);
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fp_mul_arbiter.md
FP_MUL_ARBITER -- requirements
Module: fp_mul_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters sharing one FP32 multiplier (2..8).
REQ-002 SHALL have parameter ID_W, default 2, width of requester index; SHALL equal clog2(NUM_REQ).
REQ-003 SHALL have port CLK  input  1  single clock, all state rising-edge.
REQ-004 SHALL have port RESET_N  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port req_valid  input  NUM_REQ  per-requester operation request.
REQ-006 SHALL have port req_a  input  32*NUM_REQ  packed IEEE-754 single operands A, requester i at bits [32i+31:32i].
REQ-007 SHALL have port req_b  input  32*NUM_REQ  packed operands B, same packing.
REQ-008 SHALL have port req_ready  output  NUM_REQ  grant; at most one bit high.
REQ-009 SHALL have port rsp_valid  output  1  result available.
REQ-010 SHALL have port rsp_ready  input  1  consumer accepts result.
REQ-011 SHALL have port rsp_id  output  ID_W  requester index owning the result.
REQ-012 SHALL have port rsp_result  output  32  product.
REQ-013 SHALL have port rsp_flags  output  3  {Exception, Overflow, Underflow} from the multiplier.
REQ-014 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-015 SHALL implement FSM states IDLE, EXEC, RESP (plus EXEC2 when configured, REQ-030).
REQ-016 In IDLE SHALL assert req_ready only for the round-robin winner among asserted req_valid bits; req_ready SHALL be all-zero in every other state.
REQ-017 Round-robin: search starts at pointer ptr, ascending, wrapping NUM_REQ-1 -> 0; after handshake on requester i, ptr SHALL become (i+1) mod NUM_REQ.
REQ-018 Handshake (req_valid[i] & req_ready[i]) at edge T SHALL latch req_a/req_b slice i and id i into operand registers and move IDLE -> EXEC.
REQ-019 EXEC SHALL register multiplier output into rsp_result/rsp_flags, set rsp_valid, move to RESP; rsp_valid first high in cycle T+2.
REQ-020 In RESP, rsp_id/rsp_result/rsp_flags/rsp_valid SHALL hold stable until rsp_valid & rsp_ready; then rsp_valid clears and FSM returns to IDLE.
REQ-021 With rsp_ready held high, next handshake SHALL be possible at T+3 (one outstanding operation, no overlap).
REQ-022 Requester deasserting req_valid before grant SHALL lose no state; no grant issued to a non-requesting index.
REQ-023 No request in IDLE SHALL leave ptr and all outputs unchanged.
REQ-024 Multiplier SHALL be purely combinational between operand registers and result registers; no rounding or flag changes added by this block.

Reset
REQ-025 RESET_N low SHALL asynchronously force state IDLE, ptr 0, rsp_valid 0, rsp_id 0, rsp_result 0, rsp_flags 0, busy 0, operand registers 0.
REQ-026 Reset asserted mid-operation SHALL discard the in-flight operation; no response emitted after release.
REQ-027 First grant after reset release SHALL favour requester 0.

Configuration
REQ-028 Macro FP_MUL_ARB_PIPE_EN SHALL select an extra register stage between multiplier output and response registers.
REQ-029 Without FP_MUL_ARB_PIPE_EN: latency handshake -> rsp_valid = 2 cycles, states IDLE/EXEC/RESP.
REQ-030 With FP_MUL_ARB_PIPE_EN: state EXEC2 inserted after EXEC, latency 3 cycles, minimum handshake spacing 4 cycles; all other behaviour identical.

Structure
REQ-031 Shared package SHALL hold FSM state encoding constants, FP32 width (32), flag width (3) and flag bit positions.
REQ-032 Round-robin grant logic SHALL be a sub-module rr_arbiter (inputs req vector, ptr; output one-hot grant, encoded index).
REQ-033 SHALL instantiate the team's combinational FP32 multiplier module Multiplication exactly once.

Verification
REQ-034 Single req: req_valid=0001, a=b=0x40A00000 (5.0) -> rsp_valid at T+2, rsp_id 0, rsp_result 0x41C80000, rsp_flags 000.
REQ-035 All four valid continuously, rsp_ready=1, operands 0x40000000*0x40400000 -> grants 0,1,2,3,0 at T, T+3, T+6, T+9, T+12; each result 0x40C00000.
REQ-036 Back-pressure: rsp_ready=0 for 5 cycles after rsp_valid -> outputs stable, req_ready all 0, busy 1; response accepted on first rsp_ready=1 edge.
REQ-037 Overflow: a=b=0x7F000000 on requester 2 -> rsp_id 2, rsp_flags Overflow bit set.
REQ-038 RESET_N pulsed low in EXEC -> rsp_valid stays 0, busy 0 immediately, next grant to requester 0.
REQ-039 FP_MUL_ARB_PIPE_EN defined, repeat REQ-034 -> rsp_valid at T+3, same value.
